mac_result_fifo: RTL and testbench

- Downstream stage of the square-accumulate datapath: buffers each 20-bit accumulator result presented with its valid strobe.
- Delivers results to a back-pressured consumer over a valid/ready interface.
- The accumulator has no stall input, so this block absorbs bursts and reports any result it is forced to drop.

---
 rtl/mac_result_fifo.sv | 114 +++++++++++
 tb/tb_mac_result_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_fifo.sv
// Result FIFO behind the square-accumulate datapath: show-ahead valid/ready output, sticky overflow.
// Optional MACFIFO_DROP_CNT_EN adds a saturating 8-bit count of dropped results.
module mac_result_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
`ifdef MACFIFO_DROP_CNT_EN
  output logic [7:0]             drop_cnt,
`endif
  input  logic                   clear_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t CntFull = cnt_t'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t wr_ptr_q, wr_ptr_d;
  cnt_t count_q, count_d;
  logic overflow_q, overflow_d;
  logic push, pop, drop;

  always_comb begin
    full       = (count_q == CntFull);
    empty      = (count_q == '0);
    pop        = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push       = in_valid && (!full || pop);
    drop       = in_valid && full && !pop;
    rd_ptr_d   = rd_ptr_q + ptr_t'(pop);
    wr_ptr_d   = wr_ptr_q + ptr_t'(push);
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + cnt_t'(1);
    end else if (pop && !push) begin
      count_d = count_q - cnt_t'(1);
    end
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;

`ifdef MACFIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (clear_ovf) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (clear_ovf) begin
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mac_result_fifo.sv
// Self-checking bench for mac_result_fifo: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_mac_result_fifo;

  localparam int WIDTH = 20;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       count;
  logic             full, empty, overflow;
  logic             clear_ovf = 1'b0;
`ifdef MACFIFO_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  mac_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
`ifdef MACFIFO_DROP_CNT_EN
    .drop_cnt (drop_cnt),
`endif
    .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf = 1'b0;
  int               m_dc  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the model from the pre-edge state, apply inputs, sample #1 after the edge.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit c,
                       input bit rst);
    bit m_pop, m_push;
    m_pop  = (mq.size() > 0) && r;
    m_push = v && ((mq.size() < DEPTH) || m_pop);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_dc  = 0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(d);
      if (v && !m_push) begin
        m_ovf = 1'b1;
        m_dc  = c ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
      end else if (c) begin
        m_ovf = 1'b0;
        m_dc  = 0;
      end
    end
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clear_ovf = c;
    reset     = rst;
    @(posedge clk);
    #1;
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    check("out_valid", out_valid, mq.size() != 0);
    check("out_data", out_data, (mq.size() != 0) ? mq[0] : 0);
    check("overflow", overflow, m_ovf);
`ifdef MACFIFO_DROP_CNT_EN
    check("drop_cnt", drop_cnt, m_dc);
`endif
  endtask

  typedef struct {
    bit               v;
    logic [WIDTH-1:0] d;
    bit               r;
    bit               c;
    bit               rst;
    int               exp_count;
    logic [WIDTH-1:0] exp_data;
    bit               exp_ovf;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Reset, push 1/4/9 while stalled, drain, then empty-side corner cases.
    tbl[0]  = '{0, 20'h0,     0, 0, 1, 0, 20'h0,     0};
    tbl[1]  = '{0, 20'h0,     0, 0, 0, 0, 20'h0,     0};
    tbl[2]  = '{1, 20'h00001, 0, 0, 0, 1, 20'h00001, 0};
    tbl[3]  = '{1, 20'h00004, 0, 0, 0, 2, 20'h00001, 0};
    tbl[4]  = '{1, 20'h00009, 0, 0, 0, 3, 20'h00001, 0};
    tbl[5]  = '{0, 20'h0,     1, 0, 0, 2, 20'h00004, 0};
    tbl[6]  = '{0, 20'h0,     1, 0, 0, 1, 20'h00009, 0};
    tbl[7]  = '{0, 20'h0,     1, 0, 0, 0, 20'h0,     0};
    tbl[8]  = '{0, 20'h0,     1, 0, 0, 0, 20'h0,     0};
    tbl[9]  = '{1, 20'h00005, 1, 0, 0, 1, 20'h00005, 0};
    tbl[10] = '{1, 20'h00006, 1, 0, 0, 1, 20'h00006, 0};
    tbl[11] = '{1, 20'h00007, 0, 0, 1, 0, 20'h0,     0};

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c, tbl[i].rst);
      check("tbl_count", count, tbl[i].exp_count);
      check("tbl_data", out_data, tbl[i].exp_data);
      check("tbl_ovf", overflow, tbl[i].exp_ovf);
    end

    // Fill, overflow with 0xFFFFF, drain 0x10..0x17.
    for (int i = 0; i < DEPTH; i++) cycle(1, 20'h10 + 20'(i), 0, 0, 0);
    check("fill_full", full, 1);
    cycle(1, 20'hFFFFF, 0, 0, 0);
    check("drop_count", count, 8);
    check("drop_ovf", overflow, 1);
`ifdef MACFIFO_DROP_CNT_EN
    check("drop_cnt1", drop_cnt, 1);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_data", out_data, 20'h10 + 20'(i));
      cycle(0, 20'h0, 1, 0, 0);
    end
    check("drain_empty", empty, 1);
    cycle(0, 20'h0, 0, 1, 0);
    check("clear_ovf", overflow, 0);

    // Full with simultaneous pop: accepted, no drop.
    for (int i = 0; i < DEPTH; i++) cycle(1, 20'h20 + 20'(i), 0, 0, 0);
    cycle(1, 20'hABCDE, 1, 0, 0);
    check("fullpop_count", count, 8);
    check("fullpop_ovf", overflow, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("abcde_last", out_data, 20'hABCDE);
      cycle(0, 20'h0, 1, 0, 0);
    end

    // Streaming: pointers wrap, occupancy holds at one.
    for (int i = 0; i < 20; i++) begin
      cycle(1, 20'(32'h300 + i * 7), 1, 0, 0);
      check("stream_count", count, 1);
    end
    cycle(0, 20'h0, 1, 0, 0);
    check("stream_ovf", overflow, 0);

    // Drop coinciding with clear: set wins; then clear alone.
    for (int i = 0; i < DEPTH; i++) cycle(1, 20'h40 + 20'(i), 0, 0, 0);
    cycle(1, 20'h55555, 0, 1, 0);
    check("setwins_ovf", overflow, 1);
`ifdef MACFIFO_DROP_CNT_EN
    check("setwins_dc", drop_cnt, 1);
`endif
    cycle(0, 20'h0, 0, 1, 0);
    check("clear_alone", overflow, 0);

    // Reset with count=5.
    for (int i = 0; i < 3; i++) cycle(0, 20'h0, 1, 0, 0);
    check("pre_reset_count", count, 5);
    cycle(0, 20'h0, 0, 0, 1);
    check("reset_count", count, 0);
    check("reset_empty", empty, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int unsigned mode;
      mode = (i / 500) % 3;
      cycle(($urandom_range(99) < (mode == 0 ? 80 : 40)),
            20'($urandom),
            ($urandom_range(99) < (mode == 1 ? 80 : 35)),
            ($urandom_range(99) < 3),
            ($urandom_range(999) < 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
